// File: rtl/dualmem_widen_param.sv
// ---------------------------------------------------------------------------
// dualmem_widen_param
//   Single-clock true dual-port RAM with width conversion. Port A is narrow
//   (NARROW_W bits), port B is wide (RATIO lanes of NARROW_W). Both ports view
//   one array; narrow lane k of wide word w is bits [k*NARROW_W +: NARROW_W].
//   Byte write enables, read-first on both ports, read-valid strobes and a
//   sticky write-write collision flag. Port B wins on overlapping bytes.
//
//   Optional build macro: DUALMEM_OUTREG_EN adds an output register on both
//   ports (read latency 2 instead of 1).
//
// Ports
//   clk, rstn              single clock, async active-low reset
//   ena, wea, addra, dina  narrow port access (addra = {word, lane})
//   douta, vlda            narrow read data and its valid strobe
//   enb, web, addrb, dinb  wide port access
//   doutb, vldb            wide read data and its valid strobe
//   coll                   sticky flag: overlapping byte write-write occurred
// ---------------------------------------------------------------------------
module dualmem_widen_param #(
    parameter int NARROW_W   = 16,
    parameter int RATIO      = 4,
    parameter int WIDE_DEPTH = 2048,
    localparam int WIDE_W    = NARROW_W * RATIO,
    localparam int AWB       = $clog2(WIDE_DEPTH),
    localparam int LB        = $clog2(RATIO),
    localparam int AWA       = AWB + LB,
    localparam int NB_A      = NARROW_W / 8,
    localparam int NB_B      = WIDE_W / 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ena,
    input  logic [NB_A-1:0]     wea,
    input  logic [AWA-1:0]      addra,
    input  logic [NARROW_W-1:0] dina,
    output logic [NARROW_W-1:0] douta,
    output logic                vlda,
    input  logic                enb,
    input  logic [NB_B-1:0]     web,
    input  logic [AWB-1:0]      addrb,
    input  logic [WIDE_W-1:0]   dinb,
    output logic [WIDE_W-1:0]   doutb,
    output logic                vldb,
    output logic                coll
);

    logic [WIDE_W-1:0] mem [WIDE_DEPTH];

    logic [AWB-1:0]    word_a;
    logic [LB-1:0]     lane_a;
    logic [NB_B-1:0]   wea_wide;
    logic [WIDE_W-1:0] dina_wide;
    logic              overlap;

    assign word_a    = addra[AWA-1:LB];
    assign lane_a    = addra[LB-1:0];
    assign dina_wide = {RATIO{dina}};

    // Narrow byte enables steered onto the addressed lane of the wide word.
    always_comb begin
        wea_wide = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_a == LB'(k)) begin
                wea_wide[k*NB_A +: NB_A] = wea;
            end
        end
    end

    assign overlap = ena && enb && (word_a == addrb) && (|(wea_wide & web));

    // Array: no reset. Port B's assignment comes second so it wins on any
    // byte both ports write to the same word in the same cycle.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB_B; b++) begin
            if (ena && wea_wide[b]) begin
                mem[word_a][b*8 +: 8] <= dina_wide[b*8 +: 8];
            end
            if (enb && web[b]) begin
                mem[addrb][b*8 +: 8] <= dinb[b*8 +: 8];
            end
        end
    end

    // First read stage: captures pre-write contents (read-first).
    logic [WIDE_W-1:0] word_a_q;
    logic [LB-1:0]     lane_q;
    logic              vld_a1;
    logic [WIDE_W-1:0] word_b_q;
    logic              vld_b1;
    logic [NARROW_W-1:0] douta1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_a_q <= '0;
            lane_q   <= '0;
            vld_a1   <= 1'b0;
            word_b_q <= '0;
            vld_b1   <= 1'b0;
            coll     <= 1'b0;
        end else begin
            vld_a1 <= ena;
            vld_b1 <= enb;
            if (ena) begin
                word_a_q <= mem[word_a];
                lane_q   <= lane_a;
            end
            if (enb) begin
                word_b_q <= mem[addrb];
            end
            if (overlap) begin
                coll <= 1'b1;
            end
        end
    end

    assign douta1 = word_a_q[lane_q*NARROW_W +: NARROW_W];

`ifdef DUALMEM_OUTREG_EN
    logic [NARROW_W-1:0] douta_q2;
    logic                vld_a2;
    logic [WIDE_W-1:0]   doutb_q2;
    logic                vld_b2;

    // Second stage only advances on fresh data so dout holds during idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            douta_q2 <= '0;
            vld_a2   <= 1'b0;
            doutb_q2 <= '0;
            vld_b2   <= 1'b0;
        end else begin
            vld_a2 <= vld_a1;
            vld_b2 <= vld_b1;
            if (vld_a1) begin
                douta_q2 <= douta1;
            end
            if (vld_b1) begin
                doutb_q2 <= word_b_q;
            end
        end
    end

    assign douta = douta_q2;
    assign vlda  = vld_a2;
    assign doutb = doutb_q2;
    assign vldb  = vld_b2;
`else
    assign douta = douta1;
    assign vlda  = vld_a1;
    assign doutb = word_b_q;
    assign vldb  = vld_b1;
`endif

endmodule

// File: tb/tb_dualmem_widen_param.sv
module tb_dualmem_widen_param;

    localparam int NW  = 16;
    localparam int R   = 4;
    localparam int D   = 2048;
    localparam int WW  = NW * R;
    localparam int AWB = 11;
    localparam int LB  = 2;
    localparam int AWA = AWB + LB;
`ifdef DUALMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic           ena;
    logic [1:0]     wea;
    logic [AWA-1:0] addra;
    logic [NW-1:0]  dina;
    logic [NW-1:0]  douta;
    logic           vlda;
    logic           enb;
    logic [7:0]     web;
    logic [AWB-1:0] addrb;
    logic [WW-1:0]  dinb;
    logic [WW-1:0]  doutb;
    logic           vldb;
    logic           coll;

    dualmem_widen_param #(.NARROW_W(NW), .RATIO(R), .WIDE_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .vlda(vlda),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .vldb(vldb),
        .coll(coll)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        bit          known;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic [63:0] model [D];
    bit          known [D];
    bit          coll_exp;

    // Drives one cycle of stimulus; expected read data comes from the model
    // before that cycle's writes are applied.
    task automatic access(input logic a_en, input logic [1:0] a_we,
                          input logic [AWA-1:0] a_addr, input logic [15:0] a_din,
                          input logic b_en, input logic [7:0] b_we,
                          input logic [AWB-1:0] b_addr, input logic [63:0] b_din);
        int   wi;
        int   ln;
        exp_t e;
        logic [7:0] ma;
        ena = a_en; wea = a_we; addra = a_addr; dina = a_din;
        enb = b_en; web = b_we; addrb = b_addr; dinb = b_din;
        wi = int'(a_addr[AWA-1:LB]);
        ln = int'(a_addr[LB-1:0]);
        if (a_en) begin
            e.d = 64'(model[wi][ln*16 +: 16]);
            e.known = known[wi];
            e.due = cyc + LAT;
            qa.push_back(e);
        end
        if (b_en) begin
            e.d = model[b_addr];
            e.known = known[b_addr];
            e.due = cyc + LAT;
            qb.push_back(e);
        end
        ma = 8'(a_we) << (ln * 2);
        if (a_en && b_en && wi == int'(b_addr) && (ma & b_we) != 8'h00) coll_exp = 1'b1;
        if (a_en) begin
            for (int j = 0; j < 2; j++)
                if (a_we[j]) model[wi][(ln*2+j)*8 +: 8] = a_din[j*8 +: 8];
        end
        if (b_en) begin
            for (int j = 0; j < 8; j++)
                if (b_we[j]) model[b_addr][j*8 +: 8] = b_din[j*8 +: 8];
            if (b_we == 8'hFF) known[b_addr] = 1'b1;
        end
        @(posedge clk); #1;
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (vlda) begin
                if (qa.size() == 0) chk("vlda_unexpected", 1, 0);
                else begin
                    ea = qa.pop_front();
                    if (ea.known) chk("douta", 64'(douta), ea.d);
                    chk("lat_a", 64'(cyc), 64'(ea.due));
                end
            end
            if (vldb) begin
                if (qb.size() == 0) chk("vldb_unexpected", 1, 0);
                else begin
                    eb = qb.pop_front();
                    if (eb.known) chk("doutb", doutb, eb.d);
                    chk("lat_b", 64'(cyc), 64'(eb.due));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < D; i++) begin model[i] = '0; known[i] = 1'b0; end
        coll_exp = 1'b0;
        rstn = 1'b0; ena = 0; wea = 0; addra = 0; dina = 0;
        enb = 0; web = 0; addrb = 0; dinb = 0;
        idle(3);
        chk("rst_douta", 64'(douta), 0);
        chk("rst_doutb", doutb, 0);
        chk("rst_vlda", 64'(vlda), 0);
        chk("rst_vldb", 64'(vldb), 0);
        chk("rst_coll", 64'(coll), 0);
        rstn = 1'b1;
        idle(2);

        // Wide write, narrow lane reads back-to-back.
        access(0, 2'b00, 0, 0, 1, 8'hFF, 5, 64'h4444_3333_2222_1111);
        for (int i = 20; i < 24; i++) access(1, 2'b00, AWA'(i), 0, 0, 0, 0, 0);
        idle(LAT + 2);
        chk("hold_douta", 64'(douta), 64'h4444);
        chk("idle_vlda", 64'(vlda), 0);
        chk("idle_vldb", 64'(vldb), 0);

        // Narrow writes assemble a wide word.
        access(1, 2'b11, 8,  16'hAAAA, 0, 0, 0, 0);
        access(1, 2'b11, 9,  16'hBBBB, 0, 0, 0, 0);
        access(1, 2'b11, 10, 16'hCCCC, 0, 0, 0, 0);
        access(1, 2'b11, 11, 16'hDDDD, 0, 0, 0, 0);
        access(0, 0, 0, 0, 1, 8'h00, 2, 0);
        idle(LAT + 1);
        chk("b_word2", doutb, 64'hDDDD_CCCC_BBBB_AAAA);

        // Read-first across ports.
        access(0, 0, 0, 0, 1, 8'hFF, 3, 64'h0123_4567_89AB_CDEF);
        access(1, 2'b11, 12, 16'h1234, 1, 8'h00, 3, 0);
        access(0, 0, 0, 0, 1, 8'h00, 3, 0);
        idle(LAT + 1);
        chk("b_word3_new", doutb, 64'h0123_4567_89AB_1234);

        // Same word, disjoint bytes: no collision.
        access(0, 0, 0, 0, 1, 8'hFF, 0, 64'h0);
        access(1, 2'b11, 0, 16'h5A5A, 1, 8'h0C, 0, 64'h0000_0000_7777_0000);
        idle(1);
        chk("coll_disjoint", 64'(coll), 64'(coll_exp));
        access(0, 0, 0, 0, 1, 8'h00, 0, 0);
        idle(LAT + 1);
        chk("b_word0_disjoint", doutb, 64'h0000_0000_7777_5A5A);

        // Overlapping bytes: B wins on byte 0, A's byte 1 lands.
        access(1, 2'b11, 0, 16'hFFFF, 1, 8'h01, 0, 64'h0);
        chk("coll_set", 64'(coll), 64'(coll_exp));
        access(0, 0, 0, 0, 1, 8'h00, 0, 0);
        idle(LAT + 1);
        chk("b_word0_coll", 64'(doutb[15:0]), 64'hFF00);

        // Single upper byte of lane 1 into a zeroed word; coll stays set.
        access(0, 0, 0, 0, 1, 8'hFF, 0, 64'h0);
        access(1, 2'b10, 1, 16'hAB00, 0, 0, 0, 0);
        access(0, 0, 0, 0, 1, 8'h00, 0, 0);
        idle(LAT + 1);
        chk("b_word0_byte3", doutb, 64'h0000_0000_AB00_0000);
        chk("coll_sticky", 64'(coll), 64'(coll_exp));

        // Reset with reads in flight.
        access(1, 2'b00, 22, 0, 1, 8'h00, 2, 0);
        rstn = 1'b0;
        qa.delete(); qb.delete();
        coll_exp = 1'b0;
        #2;
        chk("mid_rst_vlda", 64'(vlda), 0);
        chk("mid_rst_vldb", 64'(vldb), 0);
        chk("mid_rst_douta", 64'(douta), 0);
        chk("mid_rst_doutb", doutb, 0);
        chk("mid_rst_coll", 64'(coll), 64'(coll_exp));
        idle(2);
        rstn = 1'b1;
        idle(1);
        access(1, 2'b00, 22, 0, 1, 8'h00, 2, 0);
        idle(LAT + 1);
        chk("post_rst_douta", 64'(douta), 64'h3333);
        chk("post_rst_doutb", doutb, 64'hDDDD_CCCC_BBBB_AAAA);

        idle(4);
        chk("qa_drained", 64'(qa.size()), 0);
        chk("qb_drained", 64'(qb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
